pwm_breathe_gen: RTL and testbench

- Parametrised N-channel LED "breathing" PWM generator.
- A shared PWM counter, a duty-step prescaler and a phase accumulator drive per-channel duty values, offset in phase per channel.
- Per-channel duty is selectable among triangle, sawtooth, fixed and off modes, with glitch-free updates at PWM period boundaries.
- Sits directly behind the top-level PLL clock and drives board LED pins.

---
 rtl/pwm_breathe_gen.sv | 99 +++++++++
 tb/tb_pwm_breathe_gen.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pwm_breathe_gen.sv
// N-channel LED breathing PWM: shared period counter, phase prescaler and
// per-channel phase-offset duty generator with period-aligned shadow duties.
module pwm_breathe_gen #(
   parameter int unsigned CHANNELS   = 3,
   parameter int unsigned PWM_BITS   = 8,
   parameter int unsigned PRESC_BITS = 10,
   parameter int unsigned PHASE_STEP = 85
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                en,
   input  logic [1:0]          mode,
   input  logic [PWM_BITS-1:0] fixed_duty,
   output logic [CHANNELS-1:0] pwm_out,
   output logic                period_stb
);

   localparam int unsigned PH_W = PWM_BITS + 1;

   typedef enum logic [1:0] {
      MODE_TRI = 2'b00,
      MODE_SAW = 2'b01,
      MODE_FIX = 2'b10,
      MODE_OFF = 2'b11
   } mode_e;

   logic [PWM_BITS-1:0]                pwm_cnt_q, pwm_cnt_d;
   logic [PRESC_BITS-1:0]              presc_q, presc_d;
   logic [PH_W-1:0]                    phase_q, phase_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]  shadow_q, shadow_d;
   logic [CHANNELS-1:0][PWM_BITS-1:0]  duty_sel;
   logic [CHANNELS-1:0]                pwm_out_q, pwm_out_d;
   logic                               period_stb_q, period_stb_d;
   logic                               wrap;

   assign wrap = en & (pwm_cnt_q == '1);

   // Candidate duty per channel, from the pre-increment phase.
   always_comb begin
      logic [PH_W-1:0] ph;
      ph       = '0;
      duty_sel = '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         ph = phase_q + PH_W'(i * PHASE_STEP);
         case (mode)
            MODE_TRI: duty_sel[i] = ph[PH_W-1] ? ph[PWM_BITS-1:0] : ~ph[PWM_BITS-1:0];
            MODE_SAW: duty_sel[i] = ph[PWM_BITS-1:0];
            MODE_FIX: duty_sel[i] = fixed_duty;
            MODE_OFF: duty_sel[i] = '0;
            default:  duty_sel[i] = '0;
         endcase
      end
   end

   always_comb begin
      pwm_cnt_d    = pwm_cnt_q;
      presc_d      = presc_q;
      phase_d      = phase_q;
      shadow_d     = shadow_q;
      period_stb_d = wrap;
      pwm_out_d    = '0;
      if (en) begin
         pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
      end
      // Shadows only change at the period boundary, so no partial-period glitch.
      if (wrap) begin
         presc_d  = presc_q + PRESC_BITS'(1);
         shadow_d = duty_sel;
         if (presc_q == '1) begin
            phase_d = phase_q + PH_W'(1);
         end
      end
      for (int unsigned i = 0; i < CHANNELS; i++) begin
         pwm_out_d[i] = en & (pwm_cnt_q < shadow_q[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pwm_cnt_q    <= '0;
         presc_q      <= '0;
         phase_q      <= '0;
         shadow_q     <= '0;
         pwm_out_q    <= '0;
         period_stb_q <= 1'b0;
      end else begin
         pwm_cnt_q    <= pwm_cnt_d;
         presc_q      <= presc_d;
         phase_q      <= phase_d;
         shadow_q     <= shadow_d;
         pwm_out_q    <= pwm_out_d;
         period_stb_q <= period_stb_d;
      end
   end

   assign pwm_out    = pwm_out_q;
   assign period_stb = period_stb_q;

endmodule

// File: tb/tb_pwm_breathe_gen.sv
// Directed bench for pwm_breathe_gen (2 channels, 4-bit PWM, 2 periods per phase step).
module tb_pwm_breathe_gen;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic [1:0] mode;
   logic [3:0] fixed_duty;
   logic [1:0] pwm_out;
   logic       period_stb;

   int checks;
   int errors;

   pwm_breathe_gen #(
      .CHANNELS  (2),
      .PWM_BITS  (4),
      .PRESC_BITS(1),
      .PHASE_STEP(8)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .fixed_duty(fixed_duty),
      .pwm_out   (pwm_out),
      .period_stb(period_stb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] mode;
      logic [3:0] fd;
      int         chg_at;
      logic [1:0] cmode;
      logic [3:0] cfd;
      int         e0;
      int         e1;
   } vec_t;

   vec_t tbl[13];

   task automatic check(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
      end
   endtask

   // Triangle / sawtooth duty for a 5-bit phase value.
   function automatic int tri_duty(input int p);
      int q;
      q = p % 32;
      return (q < 16) ? 15 - q : q - 16;
   endfunction

   function automatic int saw_duty(input int p);
      return p % 16;
   endfunction

   // First 15 cycles after reset release: shadows still zero, no strobe.
   task automatic first_period(input string nm);
      int hi;
      int stb;
      hi  = 0;
      stb = 0;
      for (int j = 0; j < 15; j++) begin
         @(negedge clk);
         hi  += int'(pwm_out[0]) + int'(pwm_out[1]);
         stb += int'(period_stb);
      end
      check($sformatf("%s first_period_high", nm), hi, 0);
      check($sformatf("%s first_period_stb", nm), stb, 0);
   endtask

   // One full PWM period starting at the wrap cycle; optional mid-period input change.
   task automatic run_window(input string nm, input logic [1:0] m, input logic [3:0] fd,
                             input int chg_at, input logic [1:0] cm, input logic [3:0] cf,
                             input int e0, input int e1);
      int h0;
      int h1;
      int first_stb;
      int extra_stb;
      mode       = m;
      fixed_duty = fd;
      h0 = 0;
      h1 = 0;
      first_stb = 0;
      extra_stb = 0;
      for (int j = 0; j < 16; j++) begin
         @(negedge clk);
         if (j == 0) first_stb = int'(period_stb);
         else        extra_stb += int'(period_stb);
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
         if (j == chg_at) begin
            mode       = cm;
            fixed_duty = cf;
         end
      end
      check($sformatf("%s stb_at_start", nm), first_stb, 1);
      check($sformatf("%s stb_extra", nm), extra_stb, 0);
      check($sformatf("%s ch0_high", nm), h0, e0);
      check($sformatf("%s ch1_high", nm), h1, e1);
   endtask

   initial begin
      int h0;
      int h1;
      int stb;
      int p;
      checks = 0;
      errors = 0;

      //            mode   fd     chg  cmode  cfd    e0  e1
      tbl[0]  = '{2'b10, 4'd5,  -1, 2'b10, 4'd5,   5,  5};
      tbl[1]  = '{2'b10, 4'd5,   3, 2'b10, 4'd12,  5,  5};
      tbl[2]  = '{2'b10, 4'd12, -1, 2'b10, 4'd12, 12, 12};
      tbl[3]  = '{2'b10, 4'd12,  8, 2'b11, 4'd12, 12, 12};
      tbl[4]  = '{2'b11, 4'd12, -1, 2'b11, 4'd12,  0,  0};
      tbl[5]  = '{2'b10, 4'd0,  -1, 2'b10, 4'd0,   0,  0};
      tbl[6]  = '{2'b10, 4'd15, -1, 2'b10, 4'd15, 15, 15};
      tbl[7]  = '{2'b01, 4'd3,  -1, 2'b01, 4'd3,   3, 11};
      tbl[8]  = '{2'b01, 4'd3,  -1, 2'b01, 4'd3,   4, 12};
      tbl[9]  = '{2'b00, 4'd3,  -1, 2'b00, 4'd3,  11,  3};
      tbl[10] = '{2'b00, 4'd3,  -1, 2'b00, 4'd3,  10,  2};
      tbl[11] = '{2'b01, 4'd3,  -1, 2'b01, 4'd3,   5, 13};
      tbl[12] = '{2'b10, 4'd7,  -1, 2'b10, 4'd7,   7,  7};

      rst_n      = 1'b0;
      en         = 1'b1;
      mode       = 2'b10;
      fixed_duty = 4'd5;
      repeat (3) @(negedge clk);
      check("reset pwm_out", int'(pwm_out), 0);
      check("reset period_stb", int'(period_stb), 0);
      rst_n = 1'b1;

      first_period("boot");
      foreach (tbl[i]) begin
         run_window($sformatf("tbl%0d", i), tbl[i].mode, tbl[i].fd, tbl[i].chg_at,
                    tbl[i].cmode, tbl[i].cfd, tbl[i].e0, tbl[i].e1);
      end

      // Enable dropped at pwm_cnt=7 for 10 clocks; period resumes with the old shadow.
      mode       = 2'b10;
      fixed_duty = 4'd5;
      h0 = 0;
      h1 = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         if (j == 0) check("en_drop stb_at_start", int'(period_stb), 1);
         h0 += int'(pwm_out[0]);
         h1 += int'(pwm_out[1]);
      end
      en         = 1'b0;
      fixed_duty = 4'd9;
      stb = 0;
      p   = 0;
      for (int j = 0; j < 10; j++) begin
         @(negedge clk);
         p   += int'(pwm_out[0]) + int'(pwm_out[1]);
         stb += int'(period_stb);
      end
      check("en_low pwm_out_high", p, 0);
      check("en_low stb", stb, 0);
      en  = 1'b1;
      stb = 0;
      for (int j = 0; j < 8; j++) begin
         @(negedge clk);
         h0  += int'(pwm_out[0]);
         h1  += int'(pwm_out[1]);
         stb += int'(period_stb);
      end
      check("en_resume stb_early", stb, 0);
      check("en_resume ch0_high", h0, 5);
      check("en_resume ch1_high", h1, 5);
      run_window("after_en", 2'b10, 4'd9, -1, 2'b10, 4'd9, 9, 9);

      // Asynchronous reset while both outputs are high.
      mode       = 2'b10;
      fixed_duty = 4'd15;
      for (int j = 0; j < 5; j++) @(negedge clk);
      check("pre_rst pwm_out", int'(pwm_out), 3);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst pwm_out", int'(pwm_out), 0);
      check("async_rst period_stb", int'(period_stb), 0);
      @(negedge clk);
      @(negedge clk);
      check("held_rst pwm_out", int'(pwm_out), 0);
      mode  = 2'b00;
      rst_n = 1'b1;

      // Fresh start in triangle mode: phase 0 at first wrap, 64 periods.
      first_period("tri");
      for (int k = 1; k <= 64; k++) begin
         p = (k - 1) / 2;
         run_window($sformatf("tri_k%0d", k), 2'b00, 4'd9, -1, 2'b00, 4'd9,
                    tri_duty(p), tri_duty(p + 8));
      end
      // Sawtooth continues across the 5-bit phase wrap; fixed_duty ignored.
      for (int k = 65; k <= 100; k++) begin
         p = (k - 1) / 2;
         run_window($sformatf("saw_k%0d", k), 2'b01, 4'd9, -1, 2'b01, 4'd9,
                    saw_duty(p), saw_duty(p + 8));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
